// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data SRAM port arbiter.
// Owner tags for read return and fairness FSM states.
package mem_arb_pkg;

  localparam int SRAM_ADDR_W = 11;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

  typedef enum logic {
    S_DPRI,
    S_FPRI
  } arb_state_e;

endpackage

// File: rtl/mem_arb_fairness.sv
// Data-priority FSM with a streak counter that bounds fetch starvation.
// fetch_first flips priority to IF for one grant after MAX_STREAK DM wins.
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic fetch_first
);

  localparam logic [3:0] MAX = 4'(MAX_STREAK);

  arb_state_e state;
  arb_state_e state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [3:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_DPRI;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cnt_inc  = cnt + 4'd1;
    unique case (state)
      S_DPRI: begin
        if (dm_gnt && if_req) begin
          if (cnt_inc == MAX) begin
            state_nx = S_FPRI;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else if (if_gnt || !if_req) begin
          cnt_nx = '0;
        end
      end
      S_FPRI: begin
        if (if_gnt || !if_req) begin
          state_nx = S_DPRI;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_DPRI;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    fetch_first = (state == S_FPRI);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch (read-only) and MEM stage.
// Per-cycle grant, 1-cycle read return routed by a registered owner tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic              if_stall,
  output logic              dm_stall
);

  logic   fetch_first;
  owner_e rd_own;
  owner_e rd_own_nx;

  // Byte-lane bits and out-of-range upper bits are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  mem_arb_fairness #(
    .MAX_STREAK (MAX_STREAK)
  ) u_fair (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_gnt      (if_gnt),
    .dm_gnt      (dm_gnt),
    .fetch_first (fetch_first)
  );

  assign if_gnt = !rst && if_req && (fetch_first || !dm_req);
  assign dm_gnt = !rst && dm_req && !(fetch_first && if_req);

  assign if_stall = if_req && !if_gnt;
  assign dm_stall = dm_req && !dm_gnt;

  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    unique case (1'b1)
      if_gnt: begin
        sram_cen = 1'b0;
        sram_a   = if_addr[ADDR_W+1:2];
      end
      dm_gnt: begin
        sram_cen = 1'b0;
        sram_wen = !dm_we;
        sram_a   = dm_addr[ADDR_W+1:2];
        sram_d   = dm_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_own_nx = OWN_NONE;
    unique case (1'b1)
      if_gnt:           rd_own_nx = OWN_IF;
      dm_gnt && !dm_we: rd_own_nx = OWN_DM;
      default:          rd_own_nx = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_own <= OWN_NONE;
    end else begin
      rd_own <= rd_own_nx;
    end
  end

  assign if_rvalid = !rst && (rd_own == OWN_IF);
  assign dm_rvalid = !rst && (rd_own == OWN_DM);
  assign if_rdata  = sram_q;
  assign dm_rdata  = sram_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, contention/reset sequences,
// read-data scoreboard against a behavioural SRAM.
module tb_mem_port_arbiter;

  localparam int AW = 11;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        sram_cen;
  logic        sram_wen;
  logic [10:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;
  logic        if_stall;
  logic        dm_stall;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem     [2048];
  logic [31:0] ref_mem [2048];
  logic [31:0] q_if[$];
  logic [31:0] q_dm[$];

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        egi;
    logic        egd;
    logic        ecen;
    logic        ewen;
    logic [10:0] ea;
    logic [31:0] ed;
    logic        esi;
    logic        esd;
  } vec_t;

  vec_t vt [8];

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (32),
    .MAX_STREAK (MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 ^ (32'(i) << 4) ^ 32'(i);
  endfunction

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
    end else if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (if_rvalid) begin
      if (q_if.size() == 0) chk("if_rvalid_unexpected", 1, 0);
      else chk("if_rdata", if_rdata, q_if.pop_front());
    end
    if (dm_rvalid) begin
      if (q_dm.size() == 0) chk("dm_rvalid_unexpected", 1, 0);
      else chk("dm_rdata", dm_rdata, q_dm.pop_front());
    end
    if (if_rvalid || dm_rvalid)
      chk("rvalid_overlap", {31'b0, if_rvalid & dm_rvalid}, 0);
  end

  task automatic idle();
    if_req   = 0;
    if_addr  = 0;
    dm_req   = 0;
    dm_we    = 0;
    dm_addr  = 0;
    dm_wdata = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    next();
    rst = 0;
  endtask

  // Both requesters held; IF expected on every (MS+1)-th cycle.
  task automatic contend(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      logic eif;
      eif      = ((k % (MS + 1)) == MS);
      if_req   = 1;
      if_addr  = 32'h100;
      dm_req   = 1;
      dm_we    = 0;
      dm_addr  = 32'h200;
      if (eif) q_if.push_back(ref_mem[11'h40]);
      else q_dm.push_back(ref_mem[11'h80]);
      @(negedge clk);
      chk({nm, "_if_gnt"}, if_gnt, eif);
      chk({nm, "_dm_gnt"}, dm_gnt, !eif);
      chk({nm, "_if_stall"}, if_stall, !eif);
      chk({nm, "_dm_stall"}, dm_stall, eif);
      next();
    end
  endtask

  initial begin
    vt[0] = '{0, 0, 0, 0, 0, 0,
              0, 0, 1, 1, 11'h0, 0, 0, 0};
    vt[1] = '{1, 32'h10, 0, 0, 0, 0,
              1, 0, 0, 1, 11'h4, 0, 0, 0};
    vt[2] = '{0, 0, 1, 0, 32'h40, 0,
              0, 1, 0, 1, 11'h10, 0, 0, 0};
    vt[3] = '{0, 0, 1, 1, 32'h80, 32'h1234_5678,
              0, 1, 0, 0, 11'h20, 32'h1234_5678, 0, 0};
    vt[4] = '{1, 32'h20, 1, 0, 32'h8, 0,
              0, 1, 0, 1, 11'h2, 0, 1, 0};
    vt[5] = '{0, 0, 1, 0, 32'h2004, 0,
              0, 1, 0, 1, 11'h1, 0, 0, 0};
    vt[6] = '{1, 32'h13, 0, 0, 0, 0,
              1, 0, 0, 1, 11'h4, 0, 0, 0};
    vt[7] = '{1, 32'h2000_1FFC, 0, 0, 0, 0,
              1, 0, 0, 1, 11'h7FF, 0, 0, 0};
    for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);

    init = 1;
    rst  = 1;
    idle();
    next();
    init = 0;
    @(negedge clk);
    chk("rst_cen", sram_cen, 1);
    chk("rst_wen", sram_wen, 1);
    chk("rst_a", sram_a, 0);
    chk("rst_gnt", {if_gnt, dm_gnt}, 0);
    chk("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
    chk("rst_stall", {if_stall, dm_stall}, 0);
    next();

    for (int v = 0; v < 8; v++) begin
      do_reset();
      if_req   = vt[v].ir;
      if_addr  = vt[v].ia;
      dm_req   = vt[v].dr;
      dm_we    = vt[v].dw;
      dm_addr  = vt[v].da;
      dm_wdata = vt[v].dd;
      if (vt[v].egi) q_if.push_back(ref_mem[vt[v].ea]);
      if (vt[v].egd && !vt[v].dw) q_dm.push_back(ref_mem[vt[v].ea]);
      if (vt[v].egd && vt[v].dw) ref_mem[vt[v].ea] = vt[v].dd;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", v), if_gnt, vt[v].egi);
      chk($sformatf("v%0d_dm_gnt", v), dm_gnt, vt[v].egd);
      chk($sformatf("v%0d_cen", v), sram_cen, vt[v].ecen);
      chk($sformatf("v%0d_wen", v), sram_wen, vt[v].ewen);
      chk($sformatf("v%0d_a", v), sram_a, vt[v].ea);
      chk($sformatf("v%0d_d", v), sram_d, vt[v].ed);
      chk($sformatf("v%0d_if_stall", v), if_stall, vt[v].esi);
      chk($sformatf("v%0d_dm_stall", v), dm_stall, vt[v].esd);
      next();
      idle();
      @(negedge clk);
      chk($sformatf("v%0d_if_rvalid", v), if_rvalid, vt[v].egi);
      chk($sformatf("v%0d_dm_rvalid", v),
          dm_rvalid, vt[v].egd && !vt[v].dw);
      next();
    end

    // Write then read back through the port.
    do_reset();
    dm_req   = 1;
    dm_we    = 1;
    dm_addr  = 32'h40;
    dm_wdata = 32'hDEAD_BEEF;
    ref_mem[11'h10] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_gnt", dm_gnt, 1);
    chk("wr_wen", sram_wen, 0);
    chk("wr_a", sram_a, 11'h10);
    next();
    dm_we = 0;
    q_dm.push_back(ref_mem[11'h10]);
    @(negedge clk);
    chk("wr_no_rvalid", dm_rvalid, 0);
    chk("rd_gnt", dm_gnt, 1);
    next();
    idle();
    @(negedge clk);
    chk("rd_rvalid", dm_rvalid, 1);
    chk("rd_data", dm_rdata, 32'hDEAD_BEEF);
    next();

    // IF read then DM read: returns land on consecutive cycles.
    do_reset();
    if_req  = 1;
    if_addr = 32'h10;
    q_if.push_back(ref_mem[11'h4]);
    @(negedge clk);
    chk("seq_if_gnt", if_gnt, 1);
    next();
    idle();
    dm_req  = 1;
    dm_addr = 32'h40;
    q_dm.push_back(ref_mem[11'h10]);
    @(negedge clk);
    chk("seq_n1_gnt", dm_gnt, 1);
    chk("seq_n1_if_rvalid", if_rvalid, 1);
    chk("seq_n1_dm_rvalid", dm_rvalid, 0);
    next();
    idle();
    @(negedge clk);
    chk("seq_n2_if_rvalid", if_rvalid, 0);
    chk("seq_n2_dm_rvalid", dm_rvalid, 1);
    next();

    do_reset();
    contend(10, "cont");
    idle();
    next();

    // Build a partial streak, reset mid-read, then confirm a clean start.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if_req  = 1;
      if_addr = 32'h100;
      dm_req  = 1;
      dm_addr = 32'h2004;
      if (k < 2) q_dm.push_back(ref_mem[11'h1]);
      @(negedge clk);
      chk("pre_dm_gnt", dm_gnt, 1);
      chk("pre_a", sram_a, 11'h1);
      next();
    end
    rst = 1;
    @(negedge clk);
    chk("mid_rst_gnt", {if_gnt, dm_gnt}, 0);
    chk("mid_rst_stall", {if_stall, dm_stall}, 2'b11);
    chk("mid_rst_cen", sram_cen, 1);
    chk("mid_rst_a", sram_a, 0);
    chk("mid_rst_dm_rvalid", dm_rvalid, 0);
    next();
    rst = 0;
    contend(5, "post");
    idle();
    @(negedge clk);
    chk("idle_cen", sram_cen, 1);
    chk("idle_wen", sram_wen, 1);
    chk("idle_gnt", {if_gnt, dm_gnt}, 0);
    chk("idle_stall", {if_stall, dm_stall}, 0);
    next();
    next();

    chk("sb_if_empty", q_if.size(), 0);
    chk("sb_dm_empty", q_dm.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
